alu_sequential_divider: RTL and testbench



---
 rtl/alu_sequential_divider.sv | 104 ++++++++++
 tb/tb_alu_sequential_divider.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes in one cycle with quotient all ones and remainder = dividend.
module alu_sequential_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;

    logic [WIDTH:0]   w_partial;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;

    // Partial remainder stays below 2*divisor, so the MSB of the difference is a clean borrow.
    assign w_partial = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_partial - {1'b0, r_dvs};
    assign w_borrow  = w_diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_RUN: begin
                    r_dvd  <= r_dvd << 1;
                    r_quot <= {r_quot[WIDTH-2:0], ~w_borrow};
                    r_rem  <= w_borrow ? w_partial[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request; results hold otherwise.
                    if (start) begin
                        r_dvd <= dividend;
                        r_dvs <= divisor;
                        if (divisor == '0) begin
                            r_state <= S_DONE;
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= S_RUN;
                            r_quot  <= '0;
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(WIDTH);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_sequential_divider.sv
// Scoreboard bench for the sequential divider: stimulus pushes expected results and completion
// cycles; a negedge monitor checks busy every cycle and pops one entry per done pulse.
module tb_alu_sequential_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    alu_sequential_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_lo = 0;
    int   busy_hi = -1;
    logic [W-1:0] last_q, last_r;
    logic         last_z;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", int'(quotient), int'(e.q));
                    chk("remainder", int'(remainder), int'(e.r));
                    chk("div_by_zero", int'(div_by_zero), int'(e.z));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Called at a negedge while the DUT can accept; returns at the negedge after acceptance.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   c0;
        c0 = cyc + 1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (b == 0) begin
            e.q = '1; e.r = a; e.z = 1'b1; e.cyc = c0;
        end else begin
            e.q = W'(int'(a) / int'(b));
            e.r = W'(int'(a) % int'(b));
            e.z = 1'b0;
            e.cyc = c0 + W;
            busy_lo = c0;
            busy_hi = c0 + W - 1;
        end
        last_q = e.q; last_r = e.r; last_z = e.z;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) return;
            @(negedge clk);
        end
        chk("done_timeout", 0, 1);
    endtask

    task automatic check_hold();
        @(negedge clk);
        chk("hold_q", int'(quotient), int'(last_q));
        chk("hold_r", int'(remainder), int'(last_r));
        chk("hold_z", int'(div_by_zero), int'(last_z));
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
        issue(a, b);
        wait_done();
        check_hold();
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_q", int'(quotient), 0);
        chk("rst_r", int'(remainder), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        run_one(8'd100, 8'd7);
        run_one(8'd5, 8'd9);
        run_one(8'd255, 8'd1);
        run_one(8'd255, 8'd255);
        run_one(8'd42, 8'd0);
        run_one(8'd42, 8'd6);

        // A start while busy must be ignored.
        issue(8'd200, 8'd3);
        repeat (3) @(negedge clk);
        dividend = 8'd9; divisor = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_hold();
        repeat (12) @(negedge clk);
        chk("ignored_start_sb", sb.size(), 0);

        // Asynchronous reset mid-operation.
        issue(8'd100, 8'd7);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_q", int'(quotient), 0);
        chk("arst_r", int'(remainder), 0);
        chk("arst_z", int'(div_by_zero), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        sb.delete();
        busy_hi = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_one(8'd50, 8'd5);

        // Back-to-back: second start in the first result's done cycle.
        issue(8'd77, 8'd10);
        wait_done();
        issue(8'd13, 8'd4);
        wait_done();
        check_hold();
        @(negedge clk);

        // Random operations, mixing idle gaps and back-to-back starts.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if (($urandom_range(0, 3) == 0) && b != 0) b = W'($urandom_range(1, 4));
            issue(a, b);
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
                check_hold();
                @(negedge clk);
            end
        end
        repeat (12) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
